// File: rtl/ftdi_chk_pkg.sv
// Shared types and constants for the FTDI receive-side sequence checker.
package ftdi_chk_pkg;

    // Checker mode: hunting for an incrementing run, or locked onto one.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Bit positions inside the 4-bit led vector.
    localparam int LED_LOCK  = 0;
    localparam int LED_ERR   = 1;
    localparam int LED_HB_LO = 2;

    // Statistics counter widths.
    localparam int WCNT_W = 32;
    localparam int ECNT_W = 16;

endpackage

// File: rtl/rdy_throttle.sv
// Generates a registered otready from an 8-bit duty pattern that rotates
// right by one position every cycle, independent of otvalid.
module rdy_throttle #(
    parameter logic [7:0] RDY_PATTERN = 8'hFF
) (
    input  logic oclk,
    input  logic rst,
    output logic otready
);

    logic [7:0] pat_q;

    // Rotate the pattern each cycle; otready is the bit shifted out of position 0.
    always_ff @(posedge oclk) begin
        if (rst) begin
            pat_q   <= RDY_PATTERN;
            otready <= 1'b0;
        end else begin
            pat_q   <= {pat_q[0], pat_q[7:1]};
            otready <= pat_q[0];
        end
    end

endmodule

// File: rtl/stream_seq_checker.sv
// Sink for the host-to-FPGA recv stream of ftdi_245fifo. Checks that the
// host sends word N+1 = word N + 1 (mod 2^(8*DSIZE)), tracks lock, counts
// words and in-lock mismatches, and throttles otready with a fixed pattern.
//
// Handshake: a word transfers on a rising oclk edge where otvalid and
// otready are both high; otready is registered and does not depend on
// otvalid, and otdata is only looked at in a transfer cycle.
module stream_seq_checker
    import ftdi_chk_pkg::*;
#(
    parameter int         DSIZE       = 1,
    parameter int         LOCK_COUNT  = 4,
    parameter int         LOSS_COUNT  = 4,
    parameter logic [7:0] RDY_PATTERN = 8'hFF
) (
    input  logic                oclk,
    input  logic                rst,
    input  logic                otvalid,
    output logic                otready,
    input  logic [DSIZE*8-1:0]  otdata,
    input  logic                clear,
    output logic                locked,
    output logic [WCNT_W-1:0]   word_cnt,
    output logic [ECNT_W-1:0]   err_cnt,
    output logic [DSIZE*8-1:0]  last_exp,
    output logic [DSIZE*8-1:0]  last_got,
    output logic [3:0]          led,
    output chk_state_t          dbg_state
);

    localparam int         DW       = DSIZE * 8;
    localparam logic [7:0] RUN_LOCK = 8'(LOCK_COUNT);
    localparam logic [7:0] MISS_MAX = 8'(LOSS_COUNT);

    chk_state_t         state_q, state_n;
    logic [DW-1:0]      exp_q, exp_n;
    logic [7:0]         run_q, run_n;
    logic [7:0]         miss_q, miss_n;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_n;
    logic [ECNT_W-1:0]  ecnt_q, ecnt_n;
    logic [DW-1:0]      lexp_q, lexp_n;
    logic [DW-1:0]      lgot_q, lgot_n;
    logic               sticky_q, sticky_n;
    logic [3:0]         led_q, led_n;
    logic               accept;

    rdy_throttle #(
        .RDY_PATTERN (RDY_PATTERN)
    ) u_rdy_throttle (
        .oclk    (oclk),
        .rst     (rst),
        .otready (otready)
    );

    assign accept = otvalid & otready;

    // State register plus sequence tracking and statistics registers.
    always_ff @(posedge oclk) begin
        if (rst) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            wcnt_q   <= '0;
            ecnt_q   <= '0;
            lexp_q   <= '0;
            lgot_q   <= '0;
            sticky_q <= 1'b0;
            led_q    <= '0;
        end else begin
            state_q  <= state_n;
            exp_q    <= exp_n;
            run_q    <= run_n;
            miss_q   <= miss_n;
            wcnt_q   <= wcnt_n;
            ecnt_q   <= ecnt_n;
            lexp_q   <= lexp_n;
            lgot_q   <= lgot_n;
            sticky_q <= sticky_n;
            led_q    <= led_n;
        end
    end

    // Next-state: hunt/lock transitions on accepted words, then clear overrides the statistics.
    always_comb begin
        state_n  = state_q;
        exp_n    = exp_q;
        run_n    = run_q;
        miss_n   = miss_q;
        wcnt_n   = wcnt_q;
        ecnt_n   = ecnt_q;
        lexp_n   = lexp_q;
        lgot_n   = lgot_q;
        sticky_n = sticky_q;
        led_n    = '0;

        if (accept) begin
            wcnt_n = wcnt_q + WCNT_W'(1);
            if (state_q == HUNT) begin
                // A run only extends if a previous word set up exp.
                if ((run_q != 8'd0) && (otdata == exp_q)) begin
                    run_n = run_q + 8'd1;
                end else begin
                    run_n = 8'd1;
                end
                exp_n = otdata + DW'(1);
                if (run_n == RUN_LOCK) begin
                    state_n = LOCKED;
                    run_n   = 8'd0;
                    miss_n  = 8'd0;
                end
            end else if (otdata == exp_q) begin
                exp_n  = exp_q + DW'(1);
                miss_n = 8'd0;
            end else begin
                if (ecnt_q != '1) begin
                    ecnt_n = ecnt_q + ECNT_W'(1);
                end
                lexp_n   = exp_q;
                lgot_n   = otdata;
                sticky_n = 1'b1;
                // Resync to where the host actually is.
                exp_n    = otdata + DW'(1);
                miss_n   = miss_q + 8'd1;
                if (miss_n == MISS_MAX) begin
                    state_n = HUNT;
                    run_n   = 8'd0;
                end
            end
        end

        if (clear) begin
            wcnt_n   = '0;
            ecnt_n   = '0;
            lexp_n   = '0;
            lgot_n   = '0;
            sticky_n = 1'b0;
        end

        led_n[LED_LOCK]        = (state_n == LOCKED);
        led_n[LED_ERR]         = sticky_n;
        led_n[LED_HB_LO +: 2]  = wcnt_n[23:22];
    end

    // Outputs: all taken straight from registers.
    always_comb begin
        locked    = (state_q == LOCKED);
        dbg_state = state_q;
        word_cnt  = wcnt_q;
        err_cnt   = ecnt_q;
        last_exp  = lexp_q;
        last_got  = lgot_q;
        led       = led_q;
    end

endmodule

// File: doc/stream_seq_checker.md
Name: stream_seq_checker

Overview:
- Receive-side sink for the host-to-FPGA direction of the FTDI 245-FIFO link.
- Consumes the user recv stream of ftdi_245fifo (otvalid/otready/otdata) and verifies that the host sends an incrementing word sequence: word N+1 = word N + 1, modulo 2^(8*DSIZE).
- Reports lock state, word count, error count, last mismatch and LED status.
- Also throttles otready with a programmable pattern, so RX-FIFO backpressure paths get exercised.

Parameters:
- DSIZE, 1: recv word width in bytes (1, 2, 4 or 8); must equal OUTPUT_DSIZE of the fifo.
- LOCK_COUNT, 4: consecutive in-sequence words needed to enter LOCKED (range 2..255).
- LOSS_COUNT, 4: consecutive mismatches in LOCKED that drop back to HUNT (range 1..255).
- RDY_PATTERN, 8'hFF: 8-bit otready duty mask, rotated one bit per cycle; 8'hFF = always ready.

Ports:
- oclk  in  1  stream clock; the only clock of the block.
- rst  in  1  synchronous reset, active-high.
- otvalid  in  1  recv stream valid.
- otready  out  1  recv stream ready.
- otdata  in  DSIZE*8  recv stream data.
- clear  in  1  synchronous clear of statistics; one-cycle pulse or level.
- locked  out  1  high while in LOCKED.
- word_cnt  out  32  accepted words since reset/clear; wraps at 2^32.
- err_cnt  out  16  mismatches counted while in LOCKED; saturates at 16'hFFFF.
- last_exp  out  DSIZE*8  expected value at the most recent counted mismatch.
- last_got  out  DSIZE*8  received value at the most recent counted mismatch.
- led  out  4  [0]=locked, [1]=sticky error, [3:2]=word_cnt[23:22] heartbeat.

Behaviour:
- Reset values: otready=0, locked=0, word_cnt=0, err_cnt=0, last_exp=0, last_got=0, led=0. Internal: state=HUNT, exp=0, run=0, miss=0, pattern register=RDY_PATTERN.
- otready:
  - Registered; equals pattern bit [0].
  - Pattern rotates right by one every cycle after reset, regardless of otvalid.
  - First otready=1 occurs one cycle after rst deasserts, if RDY_PATTERN[0]=1.
- Accept: a word is accepted in a cycle where otvalid & otready. No other cycle changes exp, run, miss or counters, except clear.
- word_cnt increments on every accepted word, in both states.
- HUNT state, on each accepted word d:
  - If run>0 and d==exp: run<=run+1.
  - Otherwise: run<=1.
  - Always exp<=d+1 (wraps modulo 2^(8*DSIZE)).
  - When the updated run equals LOCK_COUNT: go to LOCKED, run<=0, miss<=0.
  - No errors are counted in HUNT.
- LOCKED state, on each accepted word d:
  - Match (d==exp): exp<=exp+1, miss<=0.
  - Mismatch:
    - err_cnt<=err_cnt+1, saturating.
    - last_exp<=exp, last_got<=d; sticky error set.
    - exp<=d+1 (resync to the new stream position), miss<=miss+1.
    - When the updated miss equals LOSS_COUNT: go to HUNT, run<=0.
- Wrap-around: all-ones followed by 0 is in-sequence (e.g. DSIZE=1: 8'hFF then 8'h00).
- Latency: locked, err_cnt, last_* and word_cnt update on the clock edge that accepts the word, so they are visible in the next cycle.
- clear:
  - Zeroes word_cnt, err_cnt, last_exp, last_got and sticky error.
  - Does not change state, exp, run, miss or the pattern.
  - A word accepted in the same cycle still updates state/exp/run/miss, but its count and error capture are discarded: clear wins.
- rst mid-stream: returns every register to its reset value on the next edge. otready drops to 0 immediately registered, so a word offered during reset is never accepted.
- led is registered from the internal registers; it has no combinational path from inputs.

Decomposition:
- Package ftdi_chk_pkg holds:
  - chk_state_t enum {HUNT, LOCKED}.
  - LED bit index constants LED_LOCK=0, LED_ERR=1, LED_HB_LO=2.
  - Counter widths WCNT_W=32, ECNT_W=16.
- One sub-module, rdy_throttle: pattern register and rotation, output otready, parameter RDY_PATTERN.
- Checker FSM and counters stay in stream_seq_checker.

Test Plan:
- Lock: DSIZE=1, RDY_PATTERN=8'hFF, words 5,6,7,8 back-to-back -> locked=1 the cycle after 8 is accepted; word_cnt=4, err_cnt=0.
- Single glitch: after lock, send 9,10,42,43,44 -> err_cnt=1, last_exp=11, last_got=42, led[1]=1, locked stays 1.
- Loss of lock: after lock, send 4 unrelated words 1,3,5,7 -> err_cnt=4, locked=0; then 20,21,22,23 -> locked=1, err_cnt unchanged at 4.
- Wrap and width: DSIZE=2, words 16'hFFFE, FFFF, 0000, 0001 -> lock with err_cnt=0. DSIZE=1, 8'hFF then 8'h00 while locked -> no error.
- Backpressure: RDY_PATTERN=8'b0000_0101, otvalid held high for 80 cycles with the data advancing only on accept -> otready high exactly 2 of every 8 cycles; word_cnt=20, err_cnt=0.
- Clear/reset collision: clear asserted in the same cycle as a mismatching accepted word -> err_cnt=0 and word_cnt=0 next cycle, exp=d+1. Then rst mid-stream -> all outputs 0 and otready=0 during reset.
